// File: rtl/lsu.sv
// Load/store unit: turns an ALU effective address into one AXI4-lite read or write beat,
// handling lane alignment, byte strobes and load extension, then pulses finish for write-back.
module lsu #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mem_en,
    input  logic [3:0]        ctrl,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] alu_result,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_finish,
    input  logic [DATA_W-1:0] rd_data,
    output logic              wr_req,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [7:0]        wr_strb,
    input  logic              wr_finish,
    output logic [DATA_W-1:0] result,
    output logic              finish,
    output logic              misaligned
);

    typedef enum logic [1:0] {StIdle, StRdWait, StWrWait, StDone} state_e;

    state_e            state_q, state_d;
    logic [3:0]        ctrl_q, ctrl_d;
    logic [2:0]        off_q, off_d;
    logic              rd_req_q, rd_req_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              wr_req_q, wr_req_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [7:0]        wr_strb_q, wr_strb_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              finish_q, finish_d;
    logic              misaligned_q, misaligned_d;

    logic              mis_req;
    logic [7:0]        size_mask;
    logic [ADDR_W-1:0] beat_addr;
    logic [DATA_W-1:0] lane;
    logic [DATA_W-1:0] load_val;

    assign beat_addr = {addr[ADDR_W-1:3], 3'b000};

    always_comb begin
        mis_req   = 1'b0;
        size_mask = 8'h01;
        unique case (ctrl[1:0])
            2'b00: begin mis_req = 1'b0;              size_mask = 8'h01; end
            2'b01: begin mis_req = addr[0];           size_mask = 8'h03; end
            2'b10: begin mis_req = |addr[1:0];        size_mask = 8'h0F; end
            2'b11: begin mis_req = |addr[2:0];        size_mask = 8'hFF; end
        endcase
    end

    // Extension uses the size/signedness latched at request time, not the live ctrl input.
    always_comb begin
        lane     = rd_data >> {off_q, 3'b000};
        load_val = lane;
        unique case (ctrl_q[1:0])
            2'b00: load_val = ctrl_q[2] ? {56'd0, lane[7:0]}  : {{56{lane[7]}},  lane[7:0]};
            2'b01: load_val = ctrl_q[2] ? {48'd0, lane[15:0]} : {{48{lane[15]}}, lane[15:0]};
            2'b10: load_val = ctrl_q[2] ? {32'd0, lane[31:0]} : {{32{lane[31]}}, lane[31:0]};
            2'b11: load_val = lane;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        ctrl_d       = ctrl_q;
        off_d        = off_q;
        rd_req_d     = rd_req_q;
        rd_addr_d    = rd_addr_q;
        wr_req_d     = wr_req_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        wr_strb_d    = wr_strb_q;
        result_d     = result_q;
        finish_d     = 1'b0;
        misaligned_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    ctrl_d = ctrl;
                    off_d  = addr[2:0];
                    if (!mem_en) begin
                        result_d = alu_result;
                        finish_d = 1'b1;
                        state_d  = StDone;
                    end else if (mis_req) begin
                        result_d     = '0;
                        finish_d     = 1'b1;
                        misaligned_d = 1'b1;
                        state_d      = StDone;
                    end else if (!ctrl[3]) begin
                        rd_req_d  = 1'b1;
                        rd_addr_d = beat_addr;
                        state_d   = StRdWait;
                    end else begin
                        wr_req_d  = 1'b1;
                        wr_addr_d = beat_addr;
                        wr_data_d = wdata << {addr[2:0], 3'b000};
                        wr_strb_d = size_mask << addr[2:0];
                        state_d   = StWrWait;
                    end
                end
            end
            StRdWait: begin
                if (rd_finish) begin
                    rd_req_d = 1'b0;
                    result_d = load_val;
                    finish_d = 1'b1;
                    state_d  = StDone;
                end
            end
            StWrWait: begin
                if (wr_finish) begin
                    wr_req_d = 1'b0;
                    result_d = '0;
                    finish_d = 1'b1;
                    state_d  = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            ctrl_q       <= '0;
            off_q        <= '0;
            rd_req_q     <= 1'b0;
            rd_addr_q    <= '0;
            wr_req_q     <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            wr_strb_q    <= '0;
            result_q     <= '0;
            finish_q     <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ctrl_q       <= ctrl_d;
            off_q        <= off_d;
            rd_req_q     <= rd_req_d;
            rd_addr_q    <= rd_addr_d;
            wr_req_q     <= wr_req_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            wr_strb_q    <= wr_strb_d;
            result_q     <= result_d;
            finish_q     <= finish_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign rd_req     = rd_req_q;
    assign rd_addr    = rd_addr_q;
    assign wr_req     = wr_req_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign wr_strb    = wr_strb_q;
    assign result     = result_q;
    assign finish     = finish_q;
    assign misaligned = misaligned_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: pass-through, loads, stores, misalignment and mid-access reset,
// with hand-computed expectations checked at the falling clock edge.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, mem_en;
    logic [3:0]  ctrl;
    logic [63:0] addr, wdata, alu_result;
    logic        rd_req, rd_finish;
    logic [63:0] rd_addr, rd_data;
    logic        wr_req, wr_finish;
    logic [63:0] wr_addr, wr_data;
    logic [7:0]  wr_strb;
    logic [63:0] result;
    logic        finish, misaligned;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lsu #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk(clk), .rst(rst), .start(start), .mem_en(mem_en), .ctrl(ctrl), .addr(addr),
        .wdata(wdata), .alu_result(alu_result), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_finish(rd_finish), .rd_data(rd_data), .wr_req(wr_req), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_strb(wr_strb), .wr_finish(wr_finish), .result(result),
        .finish(finish), .misaligned(misaligned)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Issue a load, return rd_finish after 'lat' wait cycles, check address and result.
    task automatic do_load(input string tag, input logic [3:0] c, input logic [63:0] a,
                           input logic [63:0] d, input int lat, input logic [63:0] exp_addr,
                           input logic [63:0] exp_res);
        start = 1'b1; mem_en = 1'b1; ctrl = c; addr = a;
        step();
        start = 1'b0;
        chk({tag, "_rd_req"}, 64'(rd_req), 64'd1);
        chk({tag, "_rd_addr"}, rd_addr, exp_addr);
        chk({tag, "_wr_req"}, 64'(wr_req), 64'd0);
        for (int i = 1; i < lat; i++) begin
            step();
            chk({tag, "_rd_req_hold"}, 64'(rd_req), 64'd1);
            chk({tag, "_no_finish"}, 64'(finish), 64'd0);
        end
        rd_finish = 1'b1; rd_data = d;
        step();
        rd_finish = 1'b0; rd_data = 64'hDEAD_DEAD_DEAD_DEAD;
        chk({tag, "_rd_req_drop"}, 64'(rd_req), 64'd0);
        chk({tag, "_finish"}, 64'(finish), 64'd1);
        chk({tag, "_result"}, result, exp_res);
        step();
        chk({tag, "_finish_clr"}, 64'(finish), 64'd0);
        chk({tag, "_result_hold"}, result, exp_res);
    endtask

    task automatic do_store(input string tag, input logic [3:0] c, input logic [63:0] a,
                            input logic [63:0] wd, input logic [63:0] exp_data,
                            input logic [7:0] exp_strb);
        start = 1'b1; mem_en = 1'b1; ctrl = c; addr = a; wdata = wd;
        step();
        start = 1'b0; wdata = '0;
        for (int i = 0; i < 3; i++) begin
            chk({tag, "_wr_req"}, 64'(wr_req), 64'd1);
            chk({tag, "_rd_req"}, 64'(rd_req), 64'd0);
            chk({tag, "_wr_addr"}, wr_addr, {a[63:3], 3'b000});
            chk({tag, "_wr_data"}, wr_data, exp_data);
            chk({tag, "_wr_strb"}, 64'(wr_strb), 64'(exp_strb));
            if (i < 2) step();
        end
        wr_finish = 1'b1;
        step();
        wr_finish = 1'b0;
        chk({tag, "_wr_req_drop"}, 64'(wr_req), 64'd0);
        chk({tag, "_finish"}, 64'(finish), 64'd1);
        chk({tag, "_result"}, result, 64'd0);
        step();
        chk({tag, "_finish_clr"}, 64'(finish), 64'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mem_en = 1'b0; ctrl = '0; addr = '0; wdata = '0;
        alu_result = '0; rd_finish = 1'b0; rd_data = '0; wr_finish = 1'b0;
        step(); step();
        chk("rst_rd_req", 64'(rd_req), 64'd0);
        chk("rst_wr_req", 64'(wr_req), 64'd0);
        chk("rst_finish", 64'(finish), 64'd0);
        chk("rst_misaligned", 64'(misaligned), 64'd0);
        chk("rst_result", result, 64'd0);
        chk("rst_wr_strb", 64'(wr_strb), 64'd0);
        chk("rst_rd_addr", rd_addr, 64'd0);
        rst = 1'b0;
        step();

        // Pass-through
        start = 1'b1; mem_en = 1'b0; alu_result = 64'h1234;
        step();
        start = 1'b0; alu_result = '0;
        chk("pt_finish", 64'(finish), 64'd1);
        chk("pt_result", result, 64'h1234);
        chk("pt_rd_req", 64'(rd_req), 64'd0);
        chk("pt_wr_req", 64'(wr_req), 64'd0);
        step();
        chk("pt_finish_clr", 64'(finish), 64'd0);
        chk("pt_result_hold", result, 64'h1234);

        // Bus completions in IDLE are ignored
        rd_finish = 1'b1; wr_finish = 1'b1;
        step();
        rd_finish = 1'b0; wr_finish = 1'b0;
        chk("idle_fin_ignored", 64'(finish), 64'd0);

        do_load("lb", 4'b0000, 64'h8000_0003, 64'h0000_0000_80FF_0000, 3,
                64'h8000_0000, 64'hFFFF_FFFF_FFFF_FF80);
        do_load("lwu", 4'b0110, 64'h8000_0004, 64'h89AB_CDEF_0123_4567, 1,
                64'h8000_0000, 64'h0000_0000_89AB_CDEF);
        do_load("lw", 4'b0010, 64'h8000_0004, 64'h89AB_CDEF_0123_4567, 1,
                64'h8000_0000, 64'hFFFF_FFFF_89AB_CDEF);
        do_load("lhu", 4'b0101, 64'h8000_000A, 64'h0000_0000_F00D_0000, 2,
                64'h8000_0008, 64'h0000_0000_0000_F00D);
        do_load("ld", 4'b0011, 64'h8000_0010, 64'h8877_6655_4433_2211, 1,
                64'h8000_0010, 64'h8877_6655_4433_2211);

        do_store("sh", 4'b1001, 64'h8000_0006, 64'h0000_0000_0000_BEEF,
                 64'hBEEF_0000_0000_0000, 8'hC0);
        do_store("sb", 4'b1000, 64'h8000_0017, 64'h1122_3344_5566_77AB,
                 64'hAB00_0000_0000_0000, 8'h80);
        do_store("sw", 4'b1010, 64'h8000_0004, 64'h0000_0000_CAFE_F00D,
                 64'hCAFE_F00D_0000_0000, 8'hF0);

        // Misaligned LW: no bus request, immediate finish with misaligned
        start = 1'b1; mem_en = 1'b1; ctrl = 4'b0010; addr = 64'h8000_0002;
        step();
        start = 1'b0;
        chk("mis_finish", 64'(finish), 64'd1);
        chk("mis_flag", 64'(misaligned), 64'd1);
        chk("mis_result", result, 64'd0);
        chk("mis_rd_req", 64'(rd_req), 64'd0);
        chk("mis_wr_req", 64'(wr_req), 64'd0);
        step();
        chk("mis_flag_clr", 64'(misaligned), 64'd0);
        chk("mis_finish_clr", 64'(finish), 64'd0);

        // Reset during RD_WAIT
        start = 1'b1; mem_en = 1'b1; ctrl = 4'b0011; addr = 64'h8000_0020;
        step();
        start = 1'b0;
        chk("rstmid_rd_req", 64'(rd_req), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("rstmid_rd_req_async", 64'(rd_req), 64'd0);
        chk("rstmid_rd_addr", rd_addr, 64'd0);
        step();
        rd_finish = 1'b1; rd_data = 64'h5555_5555_5555_5555;
        rst = 1'b0;
        step();
        rd_finish = 1'b0;
        chk("stale_finish", 64'(finish), 64'd0);
        chk("stale_result", result, 64'd0);
        chk("stale_rd_req", 64'(rd_req), 64'd0);
        step();
        chk("stale_finish2", 64'(finish), 64'd0);

        start = 1'b1; mem_en = 1'b0; alu_result = 64'hCAFE;
        step();
        start = 1'b0;
        chk("post_rst_finish", 64'(finish), 64'd1);
        chk("post_rst_result", result, 64'hCAFE);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit for the single-issue RV64 core, sitting directly downstream of the ALU. It takes the ALU result as an effective address, or as a plain pass-through value, and runs the memory access over the core's AXI4-lite read and write request/finish channels. It performs byte-lane alignment, store strobes and load sign/zero extension, then delivers the write-back value with a one-cycle finish pulse to the control unit.

## Interface
Parameters:
- ADDR_W, 64, address width
- DATA_W, 64, bus/data width (8 byte lanes)

Ports:
- clk  in  1  core clock; one clock domain
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle request from the control unit; sampled only in IDLE
- mem_en  in  1  instruction accesses memory; sampled with start
- ctrl  in  4  bit 3: 1 = store, 0 = load. Bit 2: 1 = unsigned load. Bits [1:0]: size, 00 = B, 01 = H, 10 = W, 11 = D
- addr  in  64  effective address from the ALU
- wdata  in  64  store data (rs2)
- alu_result  in  64  pass-through value for non-memory instructions
- rd_req  out  1  read request to the AXI4 read arbiter
- rd_addr  out  64  8-byte-aligned read address
- rd_finish  in  1  read data valid
- rd_data  in  64  read data, full 8-byte beat
- wr_req  out  1  write request
- wr_addr  out  64  8-byte-aligned write address
- wr_data  out  64  lane-shifted store data
- wr_strb  out  8  byte-lane enables
- wr_finish  in  1  write accepted
- result  out  64  write-back value
- finish  out  1  one-cycle completion pulse
- misaligned  out  1  pulses with finish when the access violates natural alignment

## Operation
- States: IDLE, RD_WAIT, WR_WAIT, DONE. All outputs are registered.
- In IDLE with start=1, latch ctrl, addr, wdata and alu_result, then:
  - mem_en=0: go to DONE with result=alu_result.
  - mem_en=1 and misaligned: go to DONE with misaligned=1 and result=0. No bus request is issued.
    - Misaligned means H with addr[0]≠0, W with addr[1:0]≠0, or D with addr[2:0]≠0.
  - Load: go to RD_WAIT. Set rd_req=1 and rd_addr={addr[63:3],3'b0}.
  - Store: go to WR_WAIT. Set wr_req=1, wr_addr={addr[63:3],3'b0}, wr_data=wdata<<(8*addr[2:0]), and wr_strb=mask<<addr[2:0].
    - mask is 0x01 for B, 0x03 for H, 0x0F for W, 0xFF for D.
- RD_WAIT: hold rd_req and rd_addr stable until rd_finish=1.
  - On that edge, set lane = rd_data>>(8*addr[2:0]) and take the low 8/16/32/64 bits.
  - Sign-extend, or zero-extend when ctrl[2]=1 (ignored for D), into result.
  - Drop rd_req and go to DONE.
- WR_WAIT: hold wr_req, wr_addr, wr_data and wr_strb stable until wr_finish=1. Then drop wr_req, set result=0 and go to DONE.
- DONE: finish=1 (and misaligned if set) for exactly one cycle, then go to IDLE. finish and misaligned clear.
- result holds its value until the next accepted start.
- start outside IDLE is ignored. rd_finish and wr_finish outside their wait states are ignored.
- rd_req and wr_req are never high together.

## Timing
- Reset (asynchronous): state=IDLE. rd_req, wr_req, finish and misaligned = 0. rd_addr, wr_addr, wr_data, result = 0. wr_strb = 0.
- Reset mid-access drops requests immediately. A completion from the bus in flight is ignored after reset.
- Non-memory or misaligned access: start at cycle t, finish=1 in cycle t+1.
- Load/store: request high from cycle t+1. If the finish input is first high in cycle k (k ≥ t+1), the request is low and finish=1 in cycle k+1.
- A new start is accepted no earlier than the cycle after finish; back-to-back throughput is 2 cycles per non-memory instruction.

## Test plan
- Pass-through: start, mem_en=0, alu_result=0x1234 -> finish and result=0x1234 at t+1; rd_req/wr_req never asserted.
- LB signed: addr=0x80000003, rd_data=0x0000000080FF0000, rd_finish 3 cycles later -> rd_addr=0x80000000, result=0xFFFFFFFFFFFFFF80, finish one cycle after rd_finish.
- LWU: addr=0x80000004, rd_data=0x89ABCDEF01234567 -> result=0x0000000089ABCDEF; repeat as LW -> 0xFFFFFFFF89ABCDEF.
- SH: addr=0x80000006, wdata=0x000000000000BEEF -> wr_addr=0x80000000, wr_strb=0xC0, wr_data=0xBEEF000000000000 held until wr_finish; result=0.
- Misaligned LW at 0x80000002 -> no request; finish=1 and misaligned=1 at t+1, result=0.
- Reset asserted during RD_WAIT -> rd_req low asynchronously; a stale rd_finish after reset is ignored. A following pass-through start completes normally.
